// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the Panda RISC-V dispatch stage: packed field widths,
// instruction-type bit positions and the execution-path encoding.
package panda_risc_v_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ID_W     = 5;
    localparam int NUM_REGS     = 32;
    localparam int INST_TYPE_W  = 7;
    localparam int ALU_OP_W     = 68;
    localparam int LSU_OP_W     = 3;
    localparam int CSR_OP_W     = 46;
    localparam int MUL_DIV_OP_W = 67;
    localparam int CNT_W        = 4;

    // Bit positions inside the packed instruction-type vector
    localparam int IDX_IS_B      = 6;
    localparam int IDX_IS_CSR_RW = 5;
    localparam int IDX_IS_LOAD   = 4;
    localparam int IDX_IS_STORE  = 3;
    localparam int IDX_IS_MUL    = 2;
    localparam int IDX_IS_DIV    = 1;
    localparam int IDX_IS_REM    = 0;

    // Execution path an instruction is routed to
    typedef enum logic [1:0] {
        DEST_ALU = 2'd0,
        DEST_CSR = 2'd1,
        DEST_MUL = 2'd2,
        DEST_DIV = 2'd3
    } dest_e;

    // CSR access has priority, then multiply, then divide/remainder; everything
    // else (branches, jumps, address generation, arithmetic) uses the ALU.
    function automatic dest_e destOf(input logic isCsr, input logic isMul,
                                     input logic isDiv, input logic isRem);
        dest_e d;
        if (isCsr)
            d = DEST_CSR;
        else if (isMul)
            d = DEST_MUL;
        else if (isDiv || isRem)
            d = DEST_DIV;
        else
            d = DEST_ALU;
        return d;
    endfunction

    // Operations whose result arrives later through the write-back port
    function automatic logic isLongOp(input logic isLoad, input logic isMul,
                                      input logic isDiv, input logic isRem);
        return isLoad | isMul | isDiv | isRem;
    endfunction

endpackage

// File: rtl/panda_risc_v_long_inst_scoreboard.sv
// Tracks long-latency results still in flight: a per-register busy vector and
// an outstanding-op counter, plus the RAW/WAW hazard and capacity checks used
// to gate acceptance of a new decode result.
module panda_risc_v_long_inst_scoreboard
    import panda_risc_v_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                sys_resetn,
    input  logic                issueLong_i,
    input  logic                issueRdVld_i,
    input  logic [REG_ID_W-1:0] issueRdId_i,
    input  logic                wbVld_i,
    input  logic [REG_ID_W-1:0] wbRdId_i,
    input  logic                heldLong_i,
    input  logic                heldRdVld_i,
    input  logic [REG_ID_W-1:0] heldRdId_i,
    input  logic                rs1Vld_i,
    input  logic [REG_ID_W-1:0] rs1Id_i,
    input  logic                rs2Vld_i,
    input  logic [REG_ID_W-1:0] rs2Id_i,
    input  logic                rdVld_i,
    input  logic [REG_ID_W-1:0] rdId_i,
    input  logic                inLong_i,
    output logic                hazard_o,
    output logic                capBlock_o
);

    localparam logic [CNT_W:0] MAX_LIM = (CNT_W+1)'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pendVld;
    logic [CNT_W:0]      capSum;

    // A register operand conflicts if it is written by an op still in flight or
    // by the long op currently waiting in the output register.
    function automatic logic regHit(input logic vld, input logic [REG_ID_W-1:0] id,
                                    input logic [NUM_REGS-1:0] busy,
                                    input logic pVld, input logic [REG_ID_W-1:0] pId);
        return vld && (id != '0) && (busy[id] || (pVld && (pId == id)));
    endfunction

    assign pendVld = heldLong_i & heldRdVld_i;

    assign hazard_o = regHit(rs1Vld_i, rs1Id_i, busy_q, pendVld, heldRdId_i) |
                      regHit(rs2Vld_i, rs2Id_i, busy_q, pendVld, heldRdId_i) |
                      regHit(rdVld_i,  rdId_i,  busy_q, pendVld, heldRdId_i);

    assign capSum     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, heldLong_i};
    assign capBlock_o = inLong_i & (capSum >= MAX_LIM);

    // Busy vector update: write-back clears, dispatch sets, set wins on a tie
    always_comb begin
        busy_d = busy_q;
        if (wbVld_i)
            busy_d[wbRdId_i] = 1'b0;
        if (issueLong_i && issueRdVld_i && (issueRdId_i != '0))
            busy_d[issueRdId_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Outstanding counter: dispatch and write-back in the same cycle cancel out
    always_comb begin
        cnt_d = cnt_q;
        if (issueLong_i && !wbVld_i && ({1'b0, cnt_q} < MAX_LIM))
            cnt_d = cnt_q + CNT_W'(1);
        else if (!issueLong_i && wbVld_i && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Scoreboard state registers
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/panda_risc_v_dispatcher.sv
// Dispatch stage: accepts decode results when no hazard or capacity limit
// blocks them, holds one instruction in an output register and routes it over
// valid/ready to exactly one of the ALU, CSR, MUL or DIV paths.
module panda_risc_v_dispatcher
    import panda_risc_v_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    sys_resetn,
    input  logic                    flush,
    input  logic                    s_dcd_valid,
    output logic                    s_dcd_ready,
    input  logic [INST_TYPE_W-1:0]  s_inst_type,
    input  logic [ALU_OP_W-1:0]     s_alu_op,
    input  logic [LSU_OP_W-1:0]     s_lsu_op,
    input  logic [CSR_OP_W-1:0]     s_csr_op,
    input  logic [MUL_DIV_OP_W-1:0] s_mul_div_op,
    input  logic [REG_ID_W-1:0]     s_rs1_id,
    input  logic [REG_ID_W-1:0]     s_rs2_id,
    input  logic [REG_ID_W-1:0]     s_rd_id,
    input  logic                    s_rs1_vld,
    input  logic                    s_rs2_vld,
    input  logic                    s_rd_vld,
    input  logic [XLEN-1:0]         s_pc,
    input  logic [XLEN-1:0]         s_pc_jump,
    output logic                    m_alu_valid,
    input  logic                    m_alu_ready,
    output logic                    m_csr_valid,
    input  logic                    m_csr_ready,
    output logic                    m_mul_valid,
    input  logic                    m_mul_ready,
    output logic                    m_div_valid,
    input  logic                    m_div_ready,
    output logic [INST_TYPE_W-1:0]  m_inst_type,
    output logic [ALU_OP_W-1:0]     m_alu_op,
    output logic [LSU_OP_W-1:0]     m_lsu_op,
    output logic [CSR_OP_W-1:0]     m_csr_op,
    output logic [MUL_DIV_OP_W-1:0] m_mul_div_op,
    output logic [REG_ID_W-1:0]     m_rd_id,
    output logic                    m_rd_vld,
    output logic [XLEN-1:0]         m_pc,
    output logic [XLEN-1:0]         m_pc_jump,
    input  logic                    wb_vld,
    input  logic [REG_ID_W-1:0]     wb_rd_id
);

    logic                    outVld_q, outVld_d;
    dest_e                   dest_q;
    logic [INST_TYPE_W-1:0]  instType_q;
    logic [ALU_OP_W-1:0]     aluOp_q;
    logic [LSU_OP_W-1:0]     lsuOp_q;
    logic [CSR_OP_W-1:0]     csrOp_q;
    logic [MUL_DIV_OP_W-1:0] mulDivOp_q;
    logic [REG_ID_W-1:0]     rdId_q;
    logic                    rdVld_q;
    logic [XLEN-1:0]         pc_q;
    logic [XLEN-1:0]         pcJump_q;

    logic  pathReady;
    logic  outFire;
    logic  accept;
    logic  heldLong;
    logic  inLong;
    logic  hazard;
    logic  capBlock;
    dest_e inDest;

    assign inDest = destOf(s_inst_type[IDX_IS_CSR_RW], s_inst_type[IDX_IS_MUL],
                           s_inst_type[IDX_IS_DIV], s_inst_type[IDX_IS_REM]);
    assign inLong = isLongOp(s_inst_type[IDX_IS_LOAD], s_inst_type[IDX_IS_MUL],
                             s_inst_type[IDX_IS_DIV], s_inst_type[IDX_IS_REM]);
    assign heldLong = outVld_q & isLongOp(instType_q[IDX_IS_LOAD], instType_q[IDX_IS_MUL],
                                          instType_q[IDX_IS_DIV], instType_q[IDX_IS_REM]);

    // Select the ready of the path the held instruction is routed to
    always_comb begin
        pathReady = 1'b0;
        case (dest_q)
            DEST_ALU: pathReady = m_alu_ready;
            DEST_CSR: pathReady = m_csr_ready;
            DEST_MUL: pathReady = m_mul_ready;
            DEST_DIV: pathReady = m_div_ready;
            default:  pathReady = 1'b0;
        endcase
    end

    assign outFire = outVld_q & pathReady;

    assign m_alu_valid = outVld_q & (dest_q == DEST_ALU);
    assign m_csr_valid = outVld_q & (dest_q == DEST_CSR);
    assign m_mul_valid = outVld_q & (dest_q == DEST_MUL);
    assign m_div_valid = outVld_q & (dest_q == DEST_DIV);

    assign s_dcd_ready = ~flush & ~hazard & ~capBlock & (~outVld_q | outFire);
    assign accept      = s_dcd_valid & s_dcd_ready;

    panda_risc_v_long_inst_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk          (clk),
        .sys_resetn   (sys_resetn),
        .issueLong_i  (outFire & heldLong),
        .issueRdVld_i (rdVld_q),
        .issueRdId_i  (rdId_q),
        .wbVld_i      (wb_vld),
        .wbRdId_i     (wb_rd_id),
        .heldLong_i   (heldLong),
        .heldRdVld_i  (rdVld_q),
        .heldRdId_i   (rdId_q),
        .rs1Vld_i     (s_rs1_vld),
        .rs1Id_i      (s_rs1_id),
        .rs2Vld_i     (s_rs2_vld),
        .rs2Id_i      (s_rs2_id),
        .rdVld_i      (s_rd_vld),
        .rdId_i       (s_rd_id),
        .inLong_i     (inLong),
        .hazard_o     (hazard),
        .capBlock_o   (capBlock)
    );

    // Output-register occupancy: flush kills, acceptance refills, handshake drains
    always_comb begin
        outVld_d = outVld_q;
        if (flush)
            outVld_d = 1'b0;
        else if (accept)
            outVld_d = 1'b1;
        else if (outFire)
            outVld_d = 1'b0;
    end

    // Occupancy flag register
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn)
            outVld_q <= 1'b0;
        else
            outVld_q <= outVld_d;
    end

    // Payload register, loaded only when a new instruction is accepted
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            dest_q     <= DEST_ALU;
            instType_q <= '0;
            aluOp_q    <= '0;
            lsuOp_q    <= '0;
            csrOp_q    <= '0;
            mulDivOp_q <= '0;
            rdId_q     <= '0;
            rdVld_q    <= 1'b0;
            pc_q       <= '0;
            pcJump_q   <= '0;
        end else if (accept) begin
            dest_q     <= inDest;
            instType_q <= s_inst_type;
            aluOp_q    <= s_alu_op;
            lsuOp_q    <= s_lsu_op;
            csrOp_q    <= s_csr_op;
            mulDivOp_q <= s_mul_div_op;
            rdId_q     <= s_rd_id;
            rdVld_q    <= s_rd_vld;
            pc_q       <= s_pc;
            pcJump_q   <= s_pc_jump;
        end
    end

    assign m_inst_type  = instType_q;
    assign m_alu_op     = aluOp_q;
    assign m_lsu_op     = lsuOp_q;
    assign m_csr_op     = csrOp_q;
    assign m_mul_div_op = mulDivOp_q;
    assign m_rd_id      = rdId_q;
    assign m_rd_vld     = rdVld_q;
    assign m_pc         = pc_q;
    assign m_pc_jump    = pcJump_q;

endmodule

// File: doc/panda_risc_v_dispatcher.md
# panda_risc_v_dispatcher

Dispatch stage of the Panda RISC-V core: consumes the packed decode results of the decoder in the same cycle they are produced, performs RAW hazard checking against long-latency results still in flight, and holds each accepted instruction in a one-entry output register. From there the instruction is routed over valid/ready to exactly one execution path: ALU, CSR, MUL or DIV. A flush from branch confirmation kills the held instruction.

## Interface
- MAX_OUTSTANDING, 4: maximum long-latency ops (load/mul/div/rem) dispatched but not yet written back; range 1..15.

Ports:
- clk  input  1  clock.
- sys_resetn  input  1  asynchronous, active-low reset.
- flush  input  1  kill the held instruction.
- s_dcd_valid  input  1  decode result valid.
- s_dcd_ready  output  1  decode result accepted.
- s_inst_type  input  7  {is_b, is_csr_rw, is_load, is_store, is_mul, is_div, is_rem}.
- s_alu_op  input  68  {alu_op_mode[3:0], alu_op1, alu_op2}.
- s_lsu_op  input  3  ls_type.
- s_csr_op  input  46  {csr_addr, csr_upd_type, csr_upd_mask_v}.
- s_mul_div_op  input  67  {op_a[32:0], op_b[32:0], mul_res_sel}.
- s_rs1_id, s_rs2_id, s_rd_id  input  5 each  register indices.
- s_rs1_vld, s_rs2_vld, s_rd_vld  input  1 each  register use flags.
- s_pc, s_pc_jump  input  32 each  instruction PC, jump target.
- m_alu_valid/m_alu_ready, m_csr_valid/m_csr_ready, m_mul_valid/m_mul_ready, m_div_valid/m_div_ready  output/input  1 each  per-path handshake.
- m_inst_type  output  7; m_alu_op 68; m_lsu_op 3; m_csr_op 46; m_mul_div_op 67; m_rd_id 5; m_rd_vld 1; m_pc 32; m_pc_jump 32. These are shared payload outputs driven from the output register.
- wb_vld  input  1  a long-latency op has completed write-back.
- wb_rd_id  input  5  destination of that op.

## Operation
- Destination:
  - CSR if is_csr_rw.
  - MUL if is_mul.
  - DIV if is_div|is_rem.
  - Otherwise ALU. This includes branch, jal/jalr, load/store address generation, LUI/AUIPC and arithmetic.
- Long op: is_load|is_mul|is_div|is_rem.
- Busy table: 32-bit vector, bit 0 held at 0.
  - Set bit rd on an output handshake of a long op with rd_vld and rd≠0.
  - Clear bit wb_rd_id on wb_vld.
  - If both hit the same index in the same cycle, set wins.
- Hazard: (s_rs1_vld & rs1≠0 & (busy[rs1] | pend_rd==rs1)), or the same for rs2, or the same for rd (WAW). pend_rd is the rd of a held long op with rd_vld.
- Outstanding counter (0..MAX_OUTSTANDING):
  - +1 on a long-op output handshake.
  - −1 on wb_vld.
  - Both in one cycle: unchanged.
  - A long input is blocked when count + held long op ≥ MAX_OUTSTANDING.
- Acceptance:
  - s_dcd_ready = ~flush & ~hazard & ~cap_block & (~out_vld | out_fire).
  - out_fire is the handshake on the held instruction's path.
- On flush: out_vld ← 0, and s_dcd_ready is 0 that cycle. The busy table and counter are unaffected, because already-dispatched ops still write back.
- Exactly one m_*_valid may be high. All are 0 when out_vld = 0.

## Timing
- Reset values:
  - out_vld = 0, so all m_*_valid = 0.
  - Payload registers = 0.
  - Busy vector = 0.
  - Counter = 0.
- Latency: an input accepted in cycle N is presented on m_* in cycle N+1.
- Throughput: 1/cycle when the target path is ready.
- Valid/ready rules:
  - m_*_valid and payload stay stable until the handshake or a flush.
  - s_dcd_ready is combinational; the upstream holds its payload while not ready.
- A same-cycle output handshake and new acceptance is legal (pipelined replace).
- A write-back in cycle N that clears a hazard allows acceptance in cycle N+1.

## Structure
- Shared package `panda_risc_v_pkg`:
  - Packed-field widths and index positions.
  - Destination encoding (ALU=0, CSR=1, MUL=2, DIV=3).
- Natural sub-module: `panda_risc_v_long_inst_scoreboard`. It holds the busy vector, the outstanding counter and the hazard/cap compare.

## Test plan
- ADD x3,x1,x2 with m_alu_ready=1: accepted in cycle 0; m_alu_valid=1 with m_rd_id=3 in cycle 1; other valids 0.
- LW x5 dispatched, then ADD x6,x5,x1:
  - ADD is stalled with s_dcd_ready=0 until wb_vld with wb_rd_id=5.
  - ADD is accepted the following cycle.
- MUL with m_mul_ready=0 for 3 cycles: m_mul_valid held and m_mul_div_op stable; s_dcd_ready=0 throughout; handshake in cycle 4.
- MAX_OUTSTANDING=2: issue two DIVs to independent rd, then a third DIV (independent rd). The third DIV is blocked until one wb_vld arrives.
- CSRRW held with m_csr_ready=0, then flush=1: m_csr_valid=0 next cycle; busy table unchanged.
- Same-cycle dispatch of LW x7 and wb_vld on x7: busy[7]=1 afterwards.
